// File: rtl/moore_pkg.sv
// Shared types and constants for the Moore FSM stimulus sequencer.
// Symbols are the 2-bit X codes the lab Moore machine consumes.
package moore_pkg;

    localparam int SYM_W = 2;

    localparam logic [SYM_W-1:0] X_IDLE = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/moore_seq_ctrl_if.sv
// Bundle of load, control, status and X/Z signals between the stimulus side
// (master) and the sequencer (slave).
interface moore_seq_ctrl_if
    import moore_pkg::*;
#(
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) ();

    logic              load_valid;
    logic [SYM_W-1:0]  load_data;
    logic              load_ready;
    logic              clear;
    logic              start;
    logic              abort;
    logic [HOLD_W-1:0] hold_cycles;
    logic              repeat_en;
    logic [SYM_W-1:0]  X;
    logic              Z;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  z_count;

    modport master (
        output load_valid, load_data, clear, start, abort, hold_cycles, repeat_en, Z,
        input  load_ready, X, busy, done, z_count
    );

    modport slave (
        input  load_valid, load_data, clear, start, abort, hold_cycles, repeat_en, Z,
        output load_ready, X, busy, done, z_count
    );

endinterface

// File: rtl/moore_sym_buf.sv
// Append-only symbol store with fill count; replayable through a combinational
// read port. Writes and clears are accepted only while the controller is idle.
module moore_sym_buf
    import moore_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int FILL_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_idle,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [SYM_W-1:0]  load_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [SYM_W-1:0]  rd_data,
    output logic [FILL_W-1:0] fill,
    output logic              load_ready
);

    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SYM_W-1:0]  mem_q [DEPTH];
    logic [SYM_W-1:0]  mem_d [DEPTH];
    logic              wr_en;

    // Clear beats a simultaneous write, so the dropped symbol never lands.
    always_comb begin
        load_ready = is_idle && (fill_q < FILL_W'(DEPTH));
        wr_en      = load_valid && load_ready && !clear;
        fill_d     = fill_q;
        mem_d      = mem_q;
        if (is_idle && clear) begin
            fill_d = '0;
        end else if (wr_en) begin
            fill_d                        = fill_q + FILL_W'(1);
            mem_d[fill_q[IDX_W-1:0]]      = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];
    assign fill    = fill_q;

endmodule

// File: rtl/moore_seq_ctrl.sv
// Replays buffered X symbols into the lab Moore FSM, holding each for a
// latched number of clocks, and counts RUN cycles where its Z output is high.
module moore_seq_ctrl
    import moore_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input logic              CLK,
    input logic              RST_N,
    moore_seq_ctrl_if.slave  bus
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FILL_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]        state_q, state_d;
    logic [SYM_W-1:0]  x_q, x_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_lat_q, hold_lat_d;
    logic              rep_lat_q, rep_lat_d;
    logic [CNT_W-1:0]  z_count_q, z_count_d;

    logic [IDX_W-1:0]  rd_addr;
    logic [SYM_W-1:0]  rd_data;
    logic [FILL_W-1:0] fill;
    logic              last_sym;
    logic              start_ok;

    moore_sym_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (CLK),
        .rst_n      (RST_N),
        .is_idle    (state_q == S_IDLE),
        .clear      (bus.clear),
        .load_valid (bus.load_valid),
        .load_data  (bus.load_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fill       (fill),
        .load_ready (bus.load_ready)
    );

    // The single read port serves both the first symbol at start and the
    // next symbol (or wrap to entry 0) during playback.
    always_comb begin
        last_sym = ({1'b0, rd_idx_q} == (fill - FILL_W'(1)));
        start_ok = bus.start && !bus.clear && (fill != '0);
        rd_addr  = '0;
        if (state_q == S_RUN && !last_sym) begin
            rd_addr = rd_idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        rd_idx_d   = rd_idx_q;
        hold_cnt_d = hold_cnt_q;
        hold_lat_d = hold_lat_q;
        rep_lat_d  = rep_lat_q;
        z_count_d  = z_count_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d    = S_RUN;
                    hold_lat_d = bus.hold_cycles;
                    rep_lat_d  = bus.repeat_en;
                    x_d        = rd_data;
                    rd_idx_d   = '0;
                    hold_cnt_d = bus.hold_cycles;
                    z_count_d  = '0;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    x_d     = X_IDLE;
                end else begin
                    if (bus.Z && (z_count_q != '1)) begin
                        z_count_d = z_count_q + CNT_W'(1);
                    end
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end else if (last_sym && !rep_lat_q) begin
                        state_d = S_DONE;
                        x_d     = X_IDLE;
                    end else begin
                        rd_idx_d   = rd_addr;
                        x_d        = rd_data;
                        hold_cnt_d = hold_lat_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                x_d     = X_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            x_q        <= X_IDLE;
            rd_idx_q   <= '0;
            hold_cnt_q <= '0;
            hold_lat_q <= '0;
            rep_lat_q  <= 1'b0;
            z_count_q  <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            rd_idx_q   <= rd_idx_d;
            hold_cnt_q <= hold_cnt_d;
            hold_lat_q <= hold_lat_d;
            rep_lat_q  <= rep_lat_d;
            z_count_q  <= z_count_d;
        end
    end

    assign bus.X       = x_q;
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.z_count = z_count_q;

endmodule

// File: doc/moore_seq_ctrl.md
Name: moore_seq_ctrl

Overview:
- Sequencer that drives the 2-bit input X of the lab Moore state machine from a programmable symbol buffer and counts cycles where its output Z is high.
- Software or a bench loads up to DEPTH symbols, then pulses start. The block replays the symbols, holding each for a programmable number of clocks, optionally looping, and signals completion.
- Sits between a stimulus source and the Moore datapath: its X output feeds the FSM's X input, and the FSM's Z output returns to this block.

Parameters:
- DEPTH, 8, number of symbol buffer entries (power of 2, ≥2)
- HOLD_W, 4, width of the per-symbol hold count
- CNT_W, 8, width of the Z-high counter

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- load_valid  in  1  symbol write request
- load_data  in  2  symbol to append
- load_ready  out  1  buffer accepts a symbol this cycle
- clear  in  1  empty the buffer (honoured in IDLE only)
- start  in  1  begin playback
- abort  in  1  stop playback immediately
- hold_cycles  in  HOLD_W  extra cycles per symbol; each symbol lasts hold_cycles+1 clocks
- repeat_en  in  1  loop playback until abort
- X  out  2  registered drive to the Moore FSM input
- Z  in  1  Moore FSM output
- busy  out  1  state is RUN
- done  out  1  one-cycle completion pulse
- z_count  out  CNT_W  number of RUN cycles with Z=1, saturating

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; X=00; busy=0; done=0; z_count=0; fill=0; rd_idx=0; hold_cnt=0.
  - Buffer contents are don't-care.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE). Both are registered state decodes.
- Buffer load:
  - load_ready=(state==IDLE && fill<DEPTH).
  - On an edge with load_valid && load_ready: buf[fill]<=load_data; fill++.
  - load_valid while not ready is dropped, with no side effect.
- clear: in IDLE, fill<=0 on the next edge. clear has priority over load in the same cycle. It is ignored outside IDLE.
- Playback does not consume entries; the buffer is replayable.
- IDLE→RUN: on an edge with start=1, fill>0 and clear=0:
  - latch hold_lat<=hold_cycles and rep_lat<=repeat_en;
  - X<=buf[0]; rd_idx<=0; hold_cnt<=hold_cycles; z_count<=0.
  - start with fill=0 is ignored.
  - start in RUN or DONE is ignored.
- RUN, each edge, in priority order:
  - If abort=1: state<=IDLE; X<=00; z_count is held; no done pulse.
  - Otherwise, if Z=1 and z_count is not all-ones, z_count++.
  - If hold_cnt!=0: hold_cnt--.
  - If hold_cnt==0 and rd_idx==fill-1 and rep_lat=0: state<=DONE; X<=00.
  - If hold_cnt==0 and rd_idx==fill-1 and rep_lat=1: rd_idx<=0; X<=buf[0]; hold_cnt<=hold_lat.
  - If hold_cnt==0 otherwise: rd_idx++; X<=buf[rd_idx+1]; hold_cnt<=hold_lat.
- DONE: lasts exactly one cycle, then IDLE. z_count holds until the next start.
- Latency and duration:
  - X shows the first symbol one cycle after start is sampled.
  - Playback length is fill*(hold_lat+1) cycles in RUN, followed by 1 cycle in DONE.
- Z is sampled only on RUN edges. It is treated as synchronous, because the FSM shares CLK.
- Changing hold_cycles or repeat_en during RUN has no effect until the next start.

Decomposition:
- Shared package moore_pkg:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding;
  - the symbol width constant SYM_W=2;
  - the idle drive constant X_IDLE=2'b00.
- One natural sub-module, moore_sym_buf: DEPTH×2 register array with write pointer and fill count, clear, a combinational read port indexed by rd_idx, and load_ready generation. The controller FSM and counters stay in the top level.

Test Plan:
- Load 00,01,10,11 with hold_cycles=1, repeat_en=0, then start → X is 00,00,01,01,10,10,11,11 over 8 cycles, then X=00 with done=1 for exactly 1 cycle, then busy=0.
- Fill to 8 entries, then assert load_valid once more → load_ready=0, the 9th symbol is dropped, and playback shows 8 symbols. Then clear together with load_valid → fill=0, and a following start is ignored (busy stays 0).
- repeat_en=1, 2 entries {01,10}, hold_cycles=0 → X alternates 01,10 indefinitely. abort at cycle 7 → next edge X=00 and state IDLE, with no done pulse.
- Tie Z=1 with CNT_W=8, 8 entries, hold_cycles=15 → 128 RUN cycles give z_count=128. Repeat with repeat_en=1 for 300 cycles → z_count saturates at 255.
- RST_N low mid-RUN at an arbitrary phase → X=00, busy=0 and z_count=0 immediately (asynchronously). After release, start with an empty buffer does nothing.
- Change hold_cycles from 0 to 3 during RUN → the current run keeps 1-cycle symbols. The next start uses 4-cycle symbols.
